// File: rtl/knn_pkg.sv
// knn_pkg: shared sizing, invalid-distance marker and FSM encoding for the KNN blocks
package knn_pkg;
  localparam int K         = 4;
  localparam int DATA_INFO = 40;
  localparam int LABEL_W   = 8;
  localparam int DIST_W    = DATA_INFO - LABEL_W;
  localparam logic [DIST_W-1:0] INV_DIST = '1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/knn_match_count.sv
// knn_match_count: number of valid entries in a list whose label equals lbl
module knn_match_count #(
  parameter int K         = knn_pkg::K,
  parameter int DATA_INFO = knn_pkg::DATA_INFO,
  parameter int LABEL_W   = knn_pkg::LABEL_W,
  localparam int CW       = $clog2(K + 1)
) (
  input  logic [K*DATA_INFO-1:0] list,
  input  logic [LABEL_W-1:0]     lbl,
  output logic [CW-1:0]          cnt
);
  localparam int DW = DATA_INFO - LABEL_W;
  // entries with an all-ones distance are empty slots and never match
  always_comb begin
    cnt = '0;
    for (int j = 0; j < K; j++)
      cnt = cnt + CW'(!(&list[j*DATA_INFO+LABEL_W +: DW]) && list[j*DATA_INFO +: LABEL_W] == lbl);
  end
endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest neighbours, nearest wins ties
module knn_vote #(
  parameter int K         = knn_pkg::K,
  parameter int DATA_INFO = knn_pkg::DATA_INFO,
  parameter int LABEL_W   = knn_pkg::LABEL_W,
  localparam int CW       = $clog2(K + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [K*DATA_INFO-1:0] nb_list,
  output logic                   busy,
  output logic                   done,
  output logic [LABEL_W-1:0]     label,
  output logic [CW-1:0]          votes,
  output logic                   empty
);
  import knn_pkg::*;
  localparam int IW = K > 1 ? $clog2(K) : 1;
  logic [1:0]             state;
  logic [K*DATA_INFO-1:0] snap;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          best_cnt, mc, cand, nb_cnt;
  logic [LABEL_W-1:0]     best_lbl, cur_lbl, nb_lbl;
  logic [DATA_INFO-1:0]   cur;
  logic                   cur_inv, take;
  knn_match_count #(.K(K), .DATA_INFO(DATA_INFO), .LABEL_W(LABEL_W)) u_count (
    .list(snap),
    .lbl (cur_lbl),
    .cnt (mc)
  );
  // score the entry under idx and decide whether it beats the current best
  always_comb begin
    cur     = snap[idx*DATA_INFO +: DATA_INFO];
    cur_lbl = cur[LABEL_W-1:0];
    cur_inv = &cur[DATA_INFO-1:LABEL_W];
    cand    = cur_inv ? '0 : mc;
    take    = cand > best_cnt;
    nb_cnt  = take ? cand : best_cnt;
    nb_lbl  = take ? cur_lbl : best_lbl;
  end
  // IDLE/DONE accept start, SCAN walks idx, results latch on the way into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      snap     <= '0;
      idx      <= '0;
      best_cnt <= '0;
      best_lbl <= '0;
      label    <= '0;
      votes    <= '0;
      empty    <= 1'b0;
    end else if (state != S_SCAN && start) begin
      state    <= S_SCAN;
      snap     <= nb_list;
      idx      <= '0;
      best_cnt <= '0;
      best_lbl <= '0;
    end else if (state == S_SCAN) begin
      best_cnt <= nb_cnt;
      best_lbl <= nb_lbl;
      idx      <= idx + IW'(1);
      if (idx == IW'(K - 1)) begin
        state <= S_DONE;
        label <= nb_lbl;
        votes <= nb_cnt;
        empty <= nb_cnt == '0;
      end
    end else begin
      state <= S_IDLE;
    end
  end
  assign busy = state == S_SCAN;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed and randomized checks of knn_vote against a list-level vote model
module tb_knn_vote;
  localparam int K  = 4;
  localparam int DI = 40;
  localparam int LW = 8;
  localparam int DW = DI - LW;
  logic          clk = 0, rst_n = 0, start = 0;
  logic [K*DI-1:0] nb_list = '0;
  logic          busy, done, empty;
  logic [LW-1:0] label;
  logic [2:0]    votes;
  int n_chk = 0, n_pass = 0;
  int m_rem = 0;
  logic m_done = 0;
  logic [11:0] m_res = '0;
  logic [K*DI-1:0] m_list = '0;

  knn_vote #(.K(K), .DATA_INFO(DI), .LABEL_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nb_list(nb_list),
    .busy(busy), .done(done), .label(label), .votes(votes), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // returns {empty, votes[2:0], label[7:0]} by counting label occurrences among valid entries
  function automatic logic [11:0] ref_vote(input logic [K*DI-1:0] l);
    int best = 0, c;
    logic [LW-1:0] bl = '0, li;
    for (int i = 0; i < K; i++) begin
      if (l[i*DI+LW +: DW] == '1) continue;
      li = l[i*DI +: LW];
      c = 0;
      for (int j = 0; j < K; j++)
        if (l[j*DI+LW +: DW] != '1 && l[j*DI +: LW] == li) c++;
      if (c > best) begin best = c; bl = li; end
    end
    return {best == 0, 3'(best), bl};
  endfunction

  function automatic logic [K*DI-1:0] mk(input logic [7:0] a, b, c, d, input logic [3:0] inv);
    logic [K*DI-1:0] l;
    logic [7:0] lb[4];
    lb = '{a, b, c, d};
    for (int i = 0; i < K; i++)
      l[i*DI +: DI] = {inv[i] ? {DW{1'b1}} : DW'(i * 10 + 1), lb[i]};
    return l;
  endfunction

  function automatic logic [K*DI-1:0] rnd_list();
    logic [K*DI-1:0] l;
    logic [DW-1:0] d;
    for (int i = 0; i < K; i++) begin
      d = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : DW'($urandom_range(0, 1000));
      l[i*DI +: DI] = {d, 8'($urandom_range(0, 3))};
    end
    return l;
  endfunction

  // model: a start seen while not scanning takes a snapshot and K scan cycles, then one done cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 0;
      m_res  <= '0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= m_rem == 1;
      if (m_rem == 1) m_res <= ref_vote(m_list);
    end else begin
      m_done <= 0;
      if (start) begin
        m_list <= nb_list;
        m_rem  <= K;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_rem > 0);
    check("done", done, m_done);
    check("label", label, m_res[7:0]);
    check("votes", votes, m_res[10:8]);
    check("empty", empty, m_res[11]);
  end

  task automatic kick(input logic [K*DI-1:0] l);
    nb_list = l;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    nb_list = rnd_list();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
  endtask

  task automatic run(input string nm, input logic [K*DI-1:0] l, input logic [7:0] el,
                     input int ev, input bit ee);
    int n;
    check({nm, "_model"}, ref_vote(l), {ee, 3'(ev), el});
    kick(l);
    wait_done(n);
    check({nm, "_lat"}, n, K + 1);
    check({nm, "_label"}, label, el);
    check({nm, "_votes"}, votes, ev);
    check({nm, "_empty"}, empty, ee);
  endtask

  initial begin
    int n, d;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_label", label, 0);
    check("rst_votes", votes, 0);
    check("rst_empty", empty, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    run("basic", mk(3, 5, 3, 7, 4'b0000), 3, 2, 0);
    run("tie", mk(5, 3, 3, 5, 4'b0000), 5, 2, 0);
    run("allinv", mk(1, 2, 3, 4, 4'b1111), 0, 0, 1);
    // start pulsed mid-scan must not restart or add a done
    nb_list = mk(9, 4, 9, 9, 4'b1100);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk); @(negedge clk);
    nb_list = mk(2, 2, 2, 2, 4'b0000);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    d = 0;
    repeat (12) begin @(negedge clk); if (done) d++; end
    check("ignore_dones", d, 1);
    check("ignore_label", label, 9);
    check("ignore_votes", votes, 1);
    // back-to-back: restart from the DONE cycle
    kick(mk(3, 5, 3, 7, 4'b0000));
    wait_done(n);
    check("b2b_first", label, 3);
    kick(mk(1, 1, 1, 1, 4'b0000));
    wait_done(n);
    check("b2b_gap", n, K + 1);
    check("b2b_label", label, 1);
    check("b2b_votes", votes, 4);
    // reset in the middle of a scan
    kick(mk(6, 6, 0, 1, 4'b0000));
    @(negedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_label", label, 0);
    check("mid_rst_votes", votes, 0);
    @(posedge clk);
    #1 rst_n = 1;
    d = 0;
    repeat (8) begin @(negedge clk); if (done) d++; end
    check("mid_rst_dones", d, 0);
    @(posedge clk); #1;
    run("after_rst", mk(6, 2, 2, 6, 4'b0001), 2, 2, 0);
    // random traffic including occasional resets, checked every cycle by the model
    repeat (1500) begin
      @(posedge clk);
      #1;
      rst_n = $urandom_range(0, 99) != 0;
      start = $urandom_range(0, 2) == 0;
      nb_list = rnd_list();
    end
    @(posedge clk);
    #1 rst_n = 1;
    start = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
